sdm_decimator_sinc1: RTL
========================

// Module: sdm_decimator_sinc1
//
// PURPOSE
// Decoder end of the iCESDM bitstream path: accepts the 1-bit sigma-delta
// stream one sample per enabled clock and counts the ones over a fixed window
// of 2^OSR_LOG2 samples (accumulate-and-dump, sinc1). Each completed window
// yields one unsigned word, handed downstream on a valid/ready interface.
// Sits between the modulator bitstream and the readout/host register logic.
//
// PARAMETERS
// OSR_LOG2   8   log2 of the decimation ratio; window N = 2^OSR_LOG2 samples
// DW         OSR_LOG2+1 (derived localparam, not overridable): output width,
//                   holds the range 0..N
//
// PORTS
// i_clk    in   1    system clock, all logic on the rising edge
// i_rst    in   1    synchronous reset, active-high
// i_en     in   1    sample strobe; i_bit is consumed on edges where i_en=1
// i_bit    in   1    bitstream sample
// i_sync   in   1    restart window: discard the partial count
// i_ready  in   1    downstream accepts o_data
// o_data   out  DW   ones-count of the last completed window
// o_valid  out  1    o_data holds an unconsumed result
// o_ovf    out  1    sticky: a result was overwritten before it was accepted
//
// BEHAVIOUR
// - Reset (i_rst=1 at an edge): accumulator, sample counter, o_data, o_valid
//   and o_ovf all become 0. Reset has priority over every other input.
//   Asserting it mid-window discards that window.
// - Sample counter s_cnt (OSR_LOG2 bits) and accumulator acc (DW bits).
//   On an edge with i_en=1 and i_sync=0:
//   * s_cnt<N-1: acc<=acc+i_bit, s_cnt<=s_cnt+1.
//   * s_cnt==N-1 (window end): o_data<=acc+i_bit, acc<=0, s_cnt<=0 (natural
//     wrap), o_valid<=1.
// - Latency: o_data/o_valid are updated on the same edge that consumes the
//   Nth enabled sample and are visible in the following cycle.
// - i_en=0: acc and s_cnt hold. The output handshake still operates.
// - i_sync=1: acc<=0, s_cnt<=0. Any sample presented on that edge is dropped.
//   o_data, o_valid and o_ovf are unaffected.
// - Handshake: a transfer occurs on an edge with o_valid=1 and i_ready=1.
//   o_valid then clears unless a window ends on the same edge; in that case
//   o_valid stays 1 with the new o_data and no overflow is flagged.
//   o_data is stable while o_valid=1 and no window ends.
// - Overflow: a window ends while o_valid=1 and i_ready=0. o_data is
//   overwritten with the newest result, o_valid stays 1 and o_ovf<=1.
//   o_ovf clears only on i_rst.
// - Arithmetic: acc cannot exceed N, so there is no saturation logic.
//   An all-ones window gives exactly N (MSB set, lower bits 0).
//
// TESTING (bench uses OSR_LOG2=3, N=8, DW=4)
// 1. rst then i_en=1, i_bit=1 for 8 cycles, i_ready=1 -> o_data=4'd8,
//    o_valid high one cycle after the 8th edge, o_ovf=0.
// 2. i_bit alternating 1,0 for 8 enabled samples -> o_data=4'd4. Then
//    8 zeros -> o_data=4'd0. Windows are back-to-back with no dropped sample.
// 3. i_en toggling every cycle, i_bit=1 -> result 8 appears only after 8
//    enabled samples (about 16 clocks). Disabled cycles do not advance s_cnt.
// 4. i_ready=0 for two full windows (all ones, then 3 ones) -> o_ovf=1,
//    o_data=4'd3, o_valid=1. Then i_ready=1 for one cycle -> o_valid=0,
//    o_ovf stays 1 until i_rst.
// 5. 5 ones, then i_sync=1 for one cycle (i_bit=1), then 8 zeros ->
//    o_data=4'd0 and no result is emitted between.
// 6. i_rst pulsed after 4 samples of a window -> all outputs 0 next cycle.
//    The next 8 ones -> o_data=4'd8. Also check a window end coinciding with
//    i_ready=1 while o_valid=1: o_valid stays 1, new data, o_ovf=0.

Source files
------------

// File: rtl/sdm_decimator_sinc1.sv
// Sinc1 (accumulate-and-dump) decimator: counts ones over 2^OSR_LOG2 enabled bitstream samples.
// Latency: the result is registered on the edge that consumes the last sample of a window and is visible the next cycle.
// Backpressure: there is a single output register; if it is still unaccepted when a new window ends, it is overwritten and o_ovf is set (sticky).
module sdm_decimator_sinc1 #(
  parameter  int OSR_LOG2 = 8,
  localparam int DW       = OSR_LOG2 + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_bit,
  input  logic          i_sync,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_ovf
);

  // The sample counter wraps naturally, so the last slot of a window is all ones.
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
  localparam logic [OSR_LOG2-1:0] CNT_ONE  = OSR_LOG2'(1);

  // Window state.
  logic [OSR_LOG2-1:0] s_cnt_q, s_cnt_d;
  logic [DW-1:0]       acc_q,   acc_d;

  // Output register state.
  logic [DW-1:0]       data_q,  data_d;
  logic                valid_q, valid_d;
  logic                ovf_q,   ovf_d;

  // Qualified events for this edge.
  logic          sample_take;
  logic          win_end;
  logic          xfer;
  logic [DW-1:0] acc_next;

  // A sample is consumed only when enabled and not restarting the window.
  always_comb begin
    sample_take = i_en && !i_sync;
    win_end     = sample_take && (s_cnt_q == CNT_LAST);
    xfer        = valid_q && i_ready;
    acc_next    = acc_q + DW'(i_bit);
  end

  // Window accumulation: sync clears and drops the sample, the last sample dumps the count.
  always_comb begin
    acc_d   = acc_q;
    s_cnt_d = s_cnt_q;
    if (i_sync) begin
      acc_d   = '0;
      s_cnt_d = '0;
    end else if (i_en) begin
      if (win_end) begin
        acc_d   = '0;
        s_cnt_d = '0;
      end else begin
        acc_d   = acc_next;
        s_cnt_d = s_cnt_q + CNT_ONE;
      end
    end
  end

  // Output register: a new result wins over a transfer on the same edge; overwriting an unaccepted result is an overflow.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (win_end) begin
      data_d  = acc_next;
      valid_d = 1'b1;
      if (valid_q && !i_ready) begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_cnt_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s_cnt_q <= s_cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;

endmodule
